// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram bin accumulator.
// Holds the FSM state encoding, control word bit positions, the read map and the status layout.
package hist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_CLEAR = 2;

  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_STATE_W   = 2;

  // Bins occupy addresses 0..num_bins-1; the summary registers follow.
  function automatic int addr_total(int num_bins);
    return num_bins;
  endfunction

  function automatic int addr_err(int num_bins);
    return num_bins + 1;
  endfunction

  function automatic int addr_status(int num_bins);
    return num_bins + 2;
  endfunction

endpackage

// File: rtl/hist_bin_accum_if.sv
// Sample, control-write and read bus of the histogram bin accumulator.
interface hist_bin_accum_if #(
  parameter int NUM_BINS = 3
);
  logic                sample_valid;
  logic [NUM_BINS-1:0] bin_idx_onehot;
  logic                wren_ctrl;
  logic [31:0]         writedata_ctrl;
  logic                rden;
  logic [31:0]         addr_rd;
  logic [31:0]         readdata;
  logic                readvalid;
  logic                done;

  modport master (
    output sample_valid, bin_idx_onehot, wren_ctrl, writedata_ctrl, rden, addr_rd,
    input  readdata, readvalid, done
  );

  modport slave (
    input  sample_valid, bin_idx_onehot, wren_ctrl, writedata_ctrl, rden, addr_rd,
    output readdata, readvalid, done
  );
endinterface

// File: rtl/hist_sat_counter.sv
// Single saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module hist_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hist_bin_accum.sv
// Histogram bin accumulator: counts one-hot bin samples per bin, plus total and malformed counts,
// under a start/stop/clear control FSM with a registered memory-mapped readback.
module hist_bin_accum
  import hist_pkg::*;
#(
  parameter int NUM_BINS = 3,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  hist_bin_accum_if.slave bus
);

  localparam int NUM_CNT = NUM_BINS + 2;

  state_e              r_state;
  state_e              w_next_state;
  logic                w_done_set;
  logic                r_drain_cnt;
  logic                r_done;
  logic                r_vld_p1;
  logic [NUM_BINS-1:0] r_idx_p1;
  logic [NUM_CNT-1:0]  w_inc;
  logic                w_clr;
  logic                w_onehot;
  logic                w_start;
  logic                w_stop;
  logic [CNT_W-1:0]    w_cnt [NUM_CNT];
  logic [31:0]         w_rd_data;
  logic [31:0]         r_readdata;
  logic                r_readvalid;
  logic                w_unused_ctrl;

  assign w_start       = bus.wren_ctrl && bus.writedata_ctrl[CTRL_START];
  assign w_stop        = bus.wren_ctrl && bus.writedata_ctrl[CTRL_STOP];
  assign w_clr         = bus.wren_ctrl && bus.writedata_ctrl[CTRL_CLEAR] && (r_state == ST_IDLE);
  assign w_unused_ctrl = ^bus.writedata_ctrl[31:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= (r_state == ST_DRAIN);
      r_done      <= w_done_set;
    end
  end

  // Drain lasts two cycles so the last RUN sample has left S1 and landed in its counter.
  always_comb begin
    w_next_state = r_state;
    w_done_set   = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start && !w_stop) w_next_state = ST_RUN;
      ST_RUN:   if (w_stop) w_next_state = ST_DRAIN;
      ST_DRAIN: begin
        if (r_drain_cnt) begin
          w_next_state = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // S1: capture samples only while running
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= bus.sample_valid && (r_state == ST_RUN);
    end
    r_idx_p1 <= bus.bin_idx_onehot;
  end

  // S2: counter updates
  always_comb begin
    w_inc    = '0;
    w_onehot = $onehot(r_idx_p1);
    for (int b = 0; b < NUM_BINS; b++) begin
      w_inc[b] = r_vld_p1 && w_onehot && r_idx_p1[b];
    end
    w_inc[addr_total(NUM_BINS)] = r_vld_p1 && w_onehot;
    w_inc[addr_err(NUM_BINS)]   = r_vld_p1 && !w_onehot;
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    hist_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_inc[g]),
      .i_clr (w_clr),
      .o_cnt (w_cnt[g])
    );
  end

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (bus.addr_rd == 32'(k)) w_rd_data = 32'(w_cnt[k]);
    end
    if (bus.addr_rd == 32'(addr_status(NUM_BINS))) begin
      w_rd_data[STATUS_STATE_LSB +: STATUS_STATE_W] = r_state;
    end
  end

  // Read stage: registered, so a read racing an S2 update sees the pre-update value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_readvalid <= 1'b0;
      r_readdata  <= '0;
    end else begin
      r_readvalid <= bus.rden;
      if (bus.rden) r_readdata <= w_rd_data;
    end
  end

  assign bus.readdata  = r_readdata;
  assign bus.readvalid = r_readvalid;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_hist_bin_accum.sv
// Bench driving a 32-bit and a 4-bit-counter accumulator in lockstep against a count-based model.
module tb_hist_bin_accum;
  import hist_pkg::*;

  localparam int    NB    = 3;
  localparam longint MAX_A = 64'hFFFF_FFFF;
  localparam longint MAX_B = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          tb_sv;
  logic [NB-1:0] tb_idx;
  logic          tb_wren;
  logic [31:0]   tb_wd;
  logic          tb_rden;
  logic [31:0]   tb_addr;

  int n_checks = 0;
  int n_err    = 0;

  longint m_bin [NB];
  longint m_tot;
  longint m_err;
  int     m_st;

  hist_bin_accum_if #(.NUM_BINS(NB)) bus_a ();
  hist_bin_accum_if #(.NUM_BINS(NB)) bus_b ();

  assign bus_a.sample_valid   = tb_sv;
  assign bus_a.bin_idx_onehot = tb_idx;
  assign bus_a.wren_ctrl      = tb_wren;
  assign bus_a.writedata_ctrl = tb_wd;
  assign bus_a.rden           = tb_rden;
  assign bus_a.addr_rd        = tb_addr;
  assign bus_b.sample_valid   = tb_sv;
  assign bus_b.bin_idx_onehot = tb_idx;
  assign bus_b.wren_ctrl      = tb_wren;
  assign bus_b.writedata_ctrl = tb_wd;
  assign bus_b.rden           = tb_rden;
  assign bus_b.addr_rd        = tb_addr;

  hist_bin_accum #(.NUM_BINS(NB), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  hist_bin_accum #(.NUM_BINS(NB), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(longint v, longint mx);
    longint r;
    r = (v > mx) ? mx : v;
    return r[31:0];
  endfunction

  function automatic logic [31:0] exp_of(int k, longint mx);
    if (k < NB)     return sat(m_bin[k], mx);
    if (k == NB)    return sat(m_tot, mx);
    if (k == NB + 1) return sat(m_err, mx);
    if (k == NB + 2) return 32'(m_st);
    return 32'd0;
  endfunction

  task automatic model_zero();
    for (int b = 0; b < NB; b++) m_bin[b] = 0;
    m_tot = 0;
    m_err = 0;
  endtask

  task automatic rd(string tag, int addr);
    tb_rden = 1'b1;
    tb_addr = 32'(addr);
    step();
    chk({tag, "_vld_a"}, 32'(bus_a.readvalid), 32'd1);
    chk({tag, "_vld_b"}, 32'(bus_b.readvalid), 32'd1);
    chk({tag, "_a"}, bus_a.readdata, exp_of(addr, MAX_A));
    chk({tag, "_b"}, bus_b.readdata, exp_of(addr, MAX_B));
    tb_rden = 1'b0;
  endtask

  task automatic read_all(string tag);
    for (int k = 0; k <= NB + 2; k++) rd($sformatf("%s_addr%0d", tag, k), k);
  endtask

  task automatic put(logic v, logic [NB-1:0] idx);
    tb_sv  = v;
    tb_idx = idx;
    step();
    if (v && m_st == 1) begin
      if ($countones(idx) == 1) begin
        for (int b = 0; b < NB; b++) if (idx[b]) m_bin[b]++;
        m_tot++;
      end else begin
        m_err++;
      end
    end
  endtask

  task automatic ctrl(logic [31:0] w);
    tb_wren = 1'b1;
    tb_wd   = w;
    step();
    tb_wren = 1'b0;
    tb_wd   = '0;
    if (w[2] && m_st == 0) model_zero();
    if (w[1]) begin
      if (m_st == 1) m_st = 2;
    end else if (w[0] && m_st == 0) begin
      m_st = 1;
    end
  endtask

  task automatic stop_drain(string tag, logic [31:0] w);
    int cyc;
    ctrl(w);
    cyc = 0;
    while (bus_a.done !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
    chk({tag, "_done_lat"}, 32'(cyc), 32'd2);
    chk({tag, "_done_b"}, 32'(bus_b.done), 32'd1);
    step();
    chk({tag, "_done_once_a"}, 32'(bus_a.done), 32'd0);
    chk({tag, "_done_once_b"}, 32'(bus_b.done), 32'd0);
    m_st = 0;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; tb_sv = 1'b0; tb_idx = '0; tb_wren = 1'b0; tb_wd = '0;
    tb_rden = 1'b0; tb_addr = '0;
    model_zero();
    m_st = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_readvalid", 32'(bus_a.readvalid), 32'd0);
    chk("rst_readdata", bus_a.readdata, 32'd0);
    chk("rst_done", 32'(bus_a.done), 32'd0);
    read_all("rst");

    // basic counting
    ctrl(32'h1);
    put(1'b1, 3'b001); put(1'b1, 3'b010); put(1'b1, 3'b100); put(1'b1, 3'b010);
    tb_sv = 1'b0;
    stop_drain("basic", 32'h2);
    read_all("basic");

    // malformed indices
    ctrl(32'h1);
    put(1'b1, 3'b000); put(1'b1, 3'b011);
    tb_sv = 1'b0;
    stop_drain("bad", 32'h2);
    read_all("bad");

    // clear ignored in RUN, honoured in IDLE
    ctrl(32'h1);
    ctrl(32'h4);
    stop_drain("clr_run", 32'h2);
    read_all("clr_run");
    ctrl(32'h4);
    read_all("clr_idle");

    // saturation
    ctrl(32'h1);
    for (int i = 0; i < 20; i++) put(1'b1, 3'b001);
    tb_sv = 1'b0;
    stop_drain("sat", 32'h2);
    read_all("sat");

    // clear + start together
    ctrl(32'h5);
    read_all("clrstart");

    // read racing an S2 update of the same counter
    for (int i = 0; i < 5; i++) put(1'b1, 3'b010);
    tb_sv = 1'b0;
    step(); step();
    put(1'b1, 3'b010);
    tb_sv   = 1'b0;
    tb_rden = 1'b1;
    tb_addr = 32'd1;
    step();
    chk("race_vld", 32'(bus_a.readvalid), 32'd1);
    chk("race_pre_a", bus_a.readdata, 32'd5);
    chk("race_pre_b", bus_b.readdata, 32'd5);
    step();
    chk("race_vld2", 32'(bus_a.readvalid), 32'd1);
    chk("race_post_a", bus_a.readdata, 32'd6);
    chk("race_post_b", bus_b.readdata, 32'd6);
    tb_rden = 1'b0;
    step();
    chk("race_vld_drop", 32'(bus_a.readvalid), 32'd0);
    rd("addr99", 99);

    // random samples
    for (int i = 0; i < 60; i++) put(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    tb_sv = 1'b0;
    stop_drain("rand", 32'h3);
    read_all("rand");
    ctrl(32'h3);
    rd("startstop_idle", NB + 2);

    // reset mid-RUN with samples in flight
    ctrl(32'h1);
    put(1'b1, 3'b001);
    tb_sv = 1'b1; tb_idx = 3'b001; rst = 1'b1;
    step();
    rst = 1'b0; tb_sv = 1'b0;
    model_zero();
    m_st = 0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus_a.done || bus_b.done) seen = 1'b1;
    end
    chk("rst_run_no_done", 32'(seen), 32'd0);
    read_all("rst_run");
    for (int i = 0; i < 3; i++) put(1'b1, 3'b100);
    tb_sv = 1'b0;
    step(); step();
    read_all("idle_drop");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hist_bin_accum.md
Name: hist_bin_accum

Overview:
- Downstream stage of the histogram range-compare controller.
- Consumes the per-sample one-hot bin index and accumulates a saturating count per bin, plus a total-sample count and a malformed-index count.
- Start, stop and clear arrive over a small control write port; all counters are read back over the same memory-mapped read style used for the range registers.

Parameters:
- NUM_BINS, 3, number of histogram bins; width of the incoming one-hot index.
- CNT_W, 32, counter width in bits (1..32); readdata is zero-extended to 32 bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_valid  in  1  bin_idx_onehot carries a sample this cycle.
- bin_idx_onehot  in  NUM_BINS  one-hot bin select from the range controller.
- wren_ctrl  in  1  control write strobe.
- writedata_ctrl  in  32  control word: bit0 start, bit1 stop, bit2 clear.
- rden  in  1  read request.
- addr_rd  in  32  read address.
- readdata  out  32  read data.
- readvalid  out  1  readdata is valid.
- done  out  1  one-cycle pulse when drain completes.

Behaviour:
- Reset: all counters 0, FSM in IDLE, readdata 0, readvalid 0, done 0, pipeline valids 0.
- Pipeline:
  - S1 registers sample_valid AND (state == RUN), together with bin_idx_onehot.
  - S2 updates the counters.
  - A sample is visible in readback 2 cycles after it is presented.
- Valid index (exactly one bit set): the selected bin increments and the total increments.
- Invalid index (zero bits or more than one bit set): only the error counter increments; no bin changes and the total does not change.
- Saturation: every counter holds at 2^CNT_W-1 and never wraps.
- FSM states:
  - IDLE -> RUN on a start write.
  - RUN -> DRAIN on a stop write.
  - DRAIN waits until S1 and S2 are empty (2 cycles), then goes to IDLE and pulses done for one cycle.
  - Start in RUN or DRAIN: ignored.
  - Stop in IDLE: ignored.
- Same control word sets both start and stop: stop wins (RUN -> DRAIN; IDLE stays IDLE).
- Clear:
  - Honoured only in IDLE.
  - Zeroes all counters on the next edge.
  - Ignored in RUN or DRAIN; no error flag is raised.
  - Clear and start in the same word while in IDLE: counters are cleared and the FSM enters RUN in that same edge.
- Samples arriving while the FSM is in IDLE or DRAIN are dropped at S1 and not counted.
- Read timing: readvalid rises exactly 1 cycle after rden and lasts 1 cycle per request. Back-to-back reads are allowed every cycle.
- Read map:
  - 0..NUM_BINS-1: bin counts.
  - NUM_BINS: total count.
  - NUM_BINS+1: error count.
  - NUM_BINS+2: status; bits[1:0] = state encoding (IDLE=0, RUN=1, DRAIN=2).
  - Any other address returns 0, with readvalid still asserted.
- A read that coincides with an S2 update of the same counter returns the pre-update value.
- rst asserted mid-RUN or mid-DRAIN: everything returns to reset values on that edge, in-flight samples are discarded, and done is not pulsed.

Decomposition:
- Package hist_pkg holds:
  - the state enum type;
  - control bit positions (CTRL_START=0, CTRL_STOP=1, CTRL_CLEAR=2);
  - read-address offset functions of NUM_BINS;
  - the status field layout.
- Sub-module hist_sat_counter is one CNT_W saturating counter with inc and clr inputs. It is instantiated NUM_BINS+2 times via a generate loop.

Test Plan:
- Start, then valid samples onehot 001,010,100,010 on consecutive cycles, stop, wait for done -> read bin0=1, bin1=2, bin2=1, total=4, err=0; done pulses exactly once, 2 cycles after stop.
- RUN with onehot 000 and then 011 -> err=2, total=0, all bins unchanged.
- CNT_W=4, 20 samples to bin0 -> bin0 reads 15 and total reads 15.
- Clear issued in RUN -> counts unchanged. Clear issued after returning to IDLE -> all addresses read 0. Clear+start in one word from IDLE -> counts 0 and status=1.
- Read bin1 in the same cycle a bin1 sample reaches S2, starting from count 5 -> readdata=5 with readvalid 1 cycle later; the next read returns 6. Read addr 99 -> 0 with readvalid asserted.
- rst asserted for 1 cycle mid-RUN with 2 samples in flight -> status=0, all counts 0, no done pulse; samples presented afterwards while IDLE are not counted.
